// File: rtl/t_down_counter.sv
// Loadable down counter built from per-bit toggle stages, with a one-cycle terminal-count pulse.
// Define T_DOWN_CNT_RELOAD_EN for periodic reload on expiry; otherwise the counter is one-shot.

module t_down_stage (
  input  logic q,
  input  logic t,
  output logic d
);
  assign d = q ^ t;
endmodule

module t_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_negative,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] dec;
`ifdef T_DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  // Bit i flips on a decrement when every bit below it is zero.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_lsb
      assign tgl[i] = 1'b1;
    end else begin : g_upper
      assign tgl[i] = ~|count[i-1:0];
    end
    t_down_stage u_stage (.q(count[i]), .t(tgl[i]), .d(dec[i]));
  end

  always_ff @(posedge clk) begin
    if (!reset_negative) begin
      count    <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      state    <= IDLE;
`ifdef T_DOWN_CNT_RELOAD_EN
      reload_q <= '0;
`endif
    end else if (load) begin
      count    <= load_value;
      tc       <= 1'b0;
      busy     <= (load_value != '0);
      state    <= (load_value != '0) ? RUN : EXPIRED;
`ifdef T_DOWN_CNT_RELOAD_EN
      reload_q <= load_value;
`endif
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (en) begin
            if (count == WIDTH'(1)) begin
              tc <= 1'b1;
`ifdef T_DOWN_CNT_RELOAD_EN
              // A RUN state implies a nonzero reload value, so no zero-length period.
              count <= reload_q;
`else
              count <= '0;
              busy  <= 1'b0;
              state <= EXPIRED;
`endif
            end else begin
              count <= dec;
            end
          end
        end
        IDLE, EXPIRED: ;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t_down_counter.sv
// Randomized and directed checks of t_down_counter against an arithmetic reference model.
// Honours T_DOWN_CNT_RELOAD_EN the same way the design does.

module tb_t_down_counter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_negative;
  logic         en;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int vectors = 0;
  int errs    = 0;

  // Reference model: 0 = never loaded, 1 = counting, 2 = expired.
  int           m_mode;
  logic [W-1:0] m_count, m_reload;
  logic         m_tc;

  t_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset_negative(reset_negative), .en(en), .load(load),
    .load_value(load_value), .count(count), .tc(tc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle past it.
  task automatic apply(input logic rst_n, input logic ld, input logic [W-1:0] lv, input logic e);
    reset_negative = rst_n;
    load           = ld;
    load_value     = lv;
    en             = e;
    @(posedge clk);
    m_tc = 1'b0;
    if (!rst_n) begin
      m_count = '0; m_reload = '0; m_mode = 0;
    end else if (ld) begin
      m_count = lv; m_reload = lv; m_mode = (lv != 0) ? 1 : 2;
    end else if (m_mode == 1 && e) begin
      if (m_count == 1) begin
        m_tc = 1'b1;
`ifdef T_DOWN_CNT_RELOAD_EN
        m_count = m_reload;
`else
        m_count = '0; m_mode = 2;
`endif
      end else begin
        m_count = m_count - 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) apply(1'b0, 1'b0, W'($urandom), 1'b1);
    vectors++;
    if ({count, tc, busy} !== {W'(0), 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset: count=%0d tc=%0b busy=%0b, want 0/0/0", count, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, W'($urandom), 1'b1);
      vectors++;
      if ({count, tc, busy} !== {m_count, m_tc, m_mode == 1}) begin
        errs++;
        $display("FAIL idle_en: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b", count, tc, busy, m_count, m_tc, m_mode == 1);
      end
    end
  endtask

  task automatic test_one_shot;
    int pulses = 0;
    apply(1'b1, 1'b1, W'(5), 1'b0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({count, tc, busy} !== {m_count, m_tc, m_mode == 1}) begin
        errs++;
        $display("FAIL count5 cyc%0d: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b", i, count, tc, busy, m_count, m_tc, m_mode == 1);
      end
      pulses += int'(tc);
      apply(1'b1, 1'b0, '0, 1'b1);
    end
`ifndef T_DOWN_CNT_RELOAD_EN
    vectors++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL count5_pulses: got %0d tc pulses, want 1", pulses);
    end
`endif
  endtask

  task automatic test_toggle;
    logic [W-1:0] exp7 = 4'b0111;
    apply(1'b1, 1'b1, W'(8), 1'b0);
    apply(1'b1, 1'b0, '0, 1'b1);
    vectors++;
    if (count !== exp7 || count !== m_count) begin
      errs++;
      $display("FAIL toggle8: count=%b, want %b", count, exp7);
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0, '0, 1'b0);
      vectors++;
      if ({count, tc, busy} !== {exp7, 1'b0, 1'b1}) begin
        errs++;
        $display("FAIL hold: count=%b tc=%0b busy=%0b, want %b/0/1", count, tc, busy, exp7);
      end
    end
  endtask

  task automatic test_load_wins;
    apply(1'b1, 1'b1, W'(9), 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, '0, 1'b1);
    apply(1'b1, 1'b1, W'(2), 1'b1);
    vectors++;
    if ({count, busy} !== {W'(2), 1'b1}) begin
      errs++;
      $display("FAIL load_wins: count=%0d busy=%0b, want 2/1", count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, '0, 1'b1);
      vectors++;
      if ({count, tc, busy} !== {m_count, m_tc, m_mode == 1}) begin
        errs++;
        $display("FAIL after_reload cyc%0d: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b", i, count, tc, busy, m_count, m_tc, m_mode == 1);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply(1'b1, 1'b1, W'(6), 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, '0, 1'b1);
    vectors++;
    if (count !== W'(3)) begin
      errs++;
      $display("FAIL pre_reset: count=%0d, want 3", count);
    end
    apply(1'b0, 1'b1, W'(7), 1'b1);
    vectors++;
    if ({count, tc, busy} !== {W'(0), 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid: count=%0d tc=%0b busy=%0b, want 0/0/0", count, tc, busy);
    end
  endtask

  task automatic test_load_zero;
    apply(1'b1, 1'b1, W'(0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({count, tc, busy} !== {W'(0), 1'b0, 1'b0}) begin
        errs++;
        $display("FAIL load_zero cyc%0d: count=%0d tc=%0b busy=%0b, want 0/0/0", i, count, tc, busy);
      end
      apply(1'b1, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) == 0), W'($urandom), ($urandom_range(0, 3) != 0));
      vectors++;
      if ({count, tc, busy} !== {m_count, m_tc, m_mode == 1}) begin
        errs++;
        $display("FAIL random cyc%0d: count=%0d tc=%0b busy=%0b, want %0d/%0b/%0b", i, count, tc, busy, m_count, m_tc, m_mode == 1);
      end
    end
  endtask

  initial begin
    m_mode = 0; m_count = '0; m_reload = '0; m_tc = 1'b0;
    reset_negative = 1'b0; en = 1'b0; load = 1'b0; load_value = '0;
    test_reset;
    test_one_shot;
    test_toggle;
    test_load_wins;
    test_reset_mid;
    test_load_zero;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
